// File: rtl/sfa_bram_dp.sv
// rtl/sfa_bram_dp.sv - true dual-port byte-write RAM with init sweep; SFA_BRAM_OUTREG_EN adds an output register stage
module sfa_bram_dp #(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = 32,
  parameter int INITIAL_VALUE = 0,
  parameter int INIT_SHIFT    = 2
) (
  input  logic                bram_clk,
  input  logic                bram_rst_n,
  input  logic                bram_init,
  output logic                init_busy,
  input  logic                bram_en_a,
  input  logic [DATA_W/8-1:0] bram_we_a,
  input  logic [ADDR_W-1:0]   bram_addr_a,
  input  logic [DATA_W-1:0]   bram_din_a,
  output logic [DATA_W-1:0]   bram_dout_a,
  output logic                bram_rvalid_a,
  output logic                bram_err_a,
  input  logic                bram_en_b,
  input  logic [DATA_W/8-1:0] bram_we_b,
  input  logic [ADDR_W-1:0]   bram_addr_b,
  input  logic [DATA_W-1:0]   bram_din_b,
  output logic [DATA_W-1:0]   bram_dout_b,
  output logic                bram_rvalid_b,
  output logic                bram_err_b
);

  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_init_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_dout_a, r_dout_b;
  logic              r_rvalid_a, r_rvalid_b;
  logic              r_err_a, r_err_b;

  logic              w_ready;
  logic              w_inr_a, w_inr_b;
  logic              w_acc_a, w_acc_b;
  logic              w_wr_a, w_wr_b;
  logic [IDX_W-1:0]  w_idx_a, w_idx_b;
  logic [DATA_W-1:0] w_init_word;

  assign w_ready     = (r_state == ST_READY);
  assign w_inr_a     = ({1'b0, bram_addr_a} < DEPTH_A);
  assign w_inr_b     = ({1'b0, bram_addr_b} < DEPTH_A);
  assign w_idx_a     = bram_addr_a[IDX_W-1:0];
  assign w_idx_b     = bram_addr_b[IDX_W-1:0];
  assign w_acc_a     = w_ready & bram_en_a;
  assign w_acc_b     = w_ready & bram_en_b;
  assign w_wr_a      = w_acc_a & w_inr_a;
  assign w_wr_b      = w_acc_b & w_inr_b;
  assign w_init_word = DATA_W'(INITIAL_VALUE) + DATA_W'(r_cnt >> INIT_SHIFT);
  assign init_busy   = r_init_busy;

  // Sweep sequencer: INIT walks every address once, READY waits for a re-init request
  always_ff @(posedge bram_clk or negedge bram_rst_n) begin
    if (!bram_rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_busy <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == LAST_IDX) begin
            r_state     <= ST_READY;
            r_cnt       <= '0;
            r_init_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        default: begin
          if (bram_init) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_busy <= 1'b1;
          end
        end
      endcase
    end
  end

  // RAM array (never reset); port B bytes first so port A's enabled bytes overwrite them on a collision
  always_ff @(posedge bram_clk) begin
    if (!w_ready) begin
      if (bram_rst_n) begin
        r_mem[r_cnt] <= w_init_word;
      end
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (w_wr_b && bram_we_b[k]) begin
          r_mem[w_idx_b][8*k +: 8] <= bram_din_b[8*k +: 8];
        end
      end
      for (int k = 0; k < NB; k++) begin
        if (w_wr_a && bram_we_a[k]) begin
          r_mem[w_idx_a][8*k +: 8] <= bram_din_a[8*k +: 8];
        end
      end
    end
  end

  // Read stage: sample the pre-write word (read-first), flag and zero out-of-range accesses
  always_ff @(posedge bram_clk or negedge bram_rst_n) begin
    if (!bram_rst_n) begin
      r_dout_a   <= '0;
      r_dout_b   <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_err_a    <= 1'b0;
      r_err_b    <= 1'b0;
    end else begin
      r_rvalid_a <= w_acc_a;
      r_rvalid_b <= w_acc_b;
      r_err_a    <= w_acc_a & ~w_inr_a;
      r_err_b    <= w_acc_b & ~w_inr_b;
      if (w_acc_a) begin
        r_dout_a <= w_inr_a ? r_mem[w_idx_a] : '0;
      end
      if (w_acc_b) begin
        r_dout_b <= w_inr_b ? r_mem[w_idx_b] : '0;
      end
    end
  end

`ifdef SFA_BRAM_OUTREG_EN
  logic [DATA_W-1:0] r_dout2_a, r_dout2_b;
  logic              r_rvalid2_a, r_rvalid2_b;
  logic              r_err2_a, r_err2_b;

  // Extra output stage; dout keeps holding because the first stage holds
  always_ff @(posedge bram_clk or negedge bram_rst_n) begin
    if (!bram_rst_n) begin
      r_dout2_a   <= '0;
      r_dout2_b   <= '0;
      r_rvalid2_a <= 1'b0;
      r_rvalid2_b <= 1'b0;
      r_err2_a    <= 1'b0;
      r_err2_b    <= 1'b0;
    end else begin
      r_dout2_a   <= r_dout_a;
      r_dout2_b   <= r_dout_b;
      r_rvalid2_a <= r_rvalid_a;
      r_rvalid2_b <= r_rvalid_b;
      r_err2_a    <= r_err_a;
      r_err2_b    <= r_err_b;
    end
  end

  assign bram_dout_a   = r_dout2_a;
  assign bram_dout_b   = r_dout2_b;
  assign bram_rvalid_a = r_rvalid2_a;
  assign bram_rvalid_b = r_rvalid2_b;
  assign bram_err_a    = r_err2_a;
  assign bram_err_b    = r_err2_b;
`else
  assign bram_dout_a   = r_dout_a;
  assign bram_dout_b   = r_dout_b;
  assign bram_rvalid_a = r_rvalid_a;
  assign bram_rvalid_b = r_rvalid_b;
  assign bram_err_a    = r_err_a;
  assign bram_err_b    = r_err_b;
`endif

endmodule

// File: tb/tb_sfa_bram_dp.sv
// tb/tb_sfa_bram_dp.sv - scoreboard bench for sfa_bram_dp
module tb_sfa_bram_dp;

  localparam int DEPTH = 256;
  localparam int IVAL  = 'h10;
`ifdef SFA_BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        bram_clk = 1'b0;
  logic        bram_rst_n = 1'b0;
  logic        bram_init = 1'b0;
  logic        init_busy;
  logic        bram_en_a = 1'b0, bram_en_b = 1'b0;
  logic [3:0]  bram_we_a = '0, bram_we_b = '0;
  logic [31:0] bram_addr_a = '0, bram_addr_b = '0;
  logic [31:0] bram_din_a = '0, bram_din_b = '0;
  logic [31:0] bram_dout_a, bram_dout_b;
  logic        bram_rvalid_a, bram_rvalid_b, bram_err_a, bram_err_b;

  sfa_bram_dp #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .INITIAL_VALUE(IVAL), .INIT_SHIFT(2)) dut (
    .bram_clk(bram_clk), .bram_rst_n(bram_rst_n), .bram_init(bram_init), .init_busy(init_busy),
    .bram_en_a(bram_en_a), .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a), .bram_din_a(bram_din_a),
    .bram_dout_a(bram_dout_a), .bram_rvalid_a(bram_rvalid_a), .bram_err_a(bram_err_a),
    .bram_en_b(bram_en_b), .bram_we_b(bram_we_b), .bram_addr_b(bram_addr_b), .bram_din_b(bram_din_b),
    .bram_dout_b(bram_dout_b), .bram_rvalid_b(bram_rvalid_b), .bram_err_b(bram_err_b)
  );

  always #5 bram_clk = ~bram_clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_a = '0, last_b = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge bram_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) model[i] = IVAL + (i >> 2);
  endtask

  // One access cycle on both ports; expectations come from the model before its update (read-first)
  task automatic step(input logic ea, input logic [3:0] wa, input logic [31:0] aa, input logic [31:0] da,
                      input logic eb, input logic [3:0] wb, input logic [31:0] ab, input logic [31:0] db,
                      input logic ign);
    exp_t x;
    bram_en_a = ea; bram_we_a = wa; bram_addr_a = aa; bram_din_a = da;
    bram_en_b = eb; bram_we_b = wb; bram_addr_b = ab; bram_din_b = db;
    if (!ign) begin
      if (ea) begin
        x.e = (aa >= DEPTH); x.d = x.e ? 32'h0 : model[aa[7:0]]; x.c = cyc + LAT;
        qa.push_back(x);
      end
      if (eb) begin
        x.e = (ab >= DEPTH); x.d = x.e ? 32'h0 : model[ab[7:0]]; x.c = cyc + LAT;
        qb.push_back(x);
      end
      if (eb && ab < DEPTH)
        for (int k = 0; k < 4; k++) if (wb[k]) model[ab[7:0]][8*k +: 8] = db[8*k +: 8];
      if (ea && aa < DEPTH)
        for (int k = 0; k < 4; k++) if (wa[k]) model[aa[7:0]][8*k +: 8] = da[8*k +: 8];
    end
    @(posedge bram_clk); #1;
    bram_en_a = 1'b0; bram_we_a = '0; bram_en_b = 1'b0; bram_we_b = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Count busy cycles from reset release; optionally pulse bram_init mid-sweep (must be ignored)
  task automatic wait_init(input int pulse_at, output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge bram_clk);
      if (!init_busy) break;
      n++;
      bram_init = (i == pulse_at);
    end
    bram_init = 1'b0;
    @(posedge bram_clk); #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_dout_a", bram_dout_a, 0);
    chk("rst_dout_b", bram_dout_b, 0);
    chk("rst_rvalid", {bram_rvalid_a, bram_rvalid_b}, 0);
    chk("rst_err", {bram_err_a, bram_err_b}, 0);
    chk("rst_busy", init_busy, 1);
  endtask

  // Output monitor: pop and compare on each rvalid, catch spurious and missing responses
  always @(negedge bram_clk) begin
    exp_t x;
    if (bram_rst_n) begin
      if (qa.size() > 0 && qa[0].c < cyc) begin
        chk("a_missing", 0, 1);
        x = qa.pop_front();
      end
      if (qb.size() > 0 && qb[0].c < cyc) begin
        chk("b_missing", 0, 1);
        x = qb.pop_front();
      end
      if (bram_rvalid_a) begin
        if (qa.size() == 0) chk("a_spurious", 1, 0);
        else begin
          x = qa.pop_front();
          chk("a_data", bram_dout_a, x.d);
          chk("a_err", bram_err_a, x.e);
          chk("a_lat", cyc, x.c);
          last_a = x.d;
        end
      end else if (bram_err_a) chk("a_err_novalid", 1, 0);
      if (bram_rvalid_b) begin
        if (qb.size() == 0) chk("b_spurious", 1, 0);
        else begin
          x = qb.pop_front();
          chk("b_data", bram_dout_b, x.d);
          chk("b_err", bram_err_b, x.e);
          chk("b_lat", cyc, x.c);
          last_b = x.d;
        end
      end else if (bram_err_b) chk("b_err_novalid", 1, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] aa, ab;
    repeat (3) @(posedge bram_clk);
    #1;
    chk_reset_vals();

    // power-up sweep, with an ignored re-init request in the middle
    bram_rst_n = 1'b1;
    wait_init(5, n);
    chk("init_len", n, DEPTH);
    model_init();

    // init pattern reads
    step(1, 0, 0, 0, 1, 0, 5, 0, 0);
    step(1, 0, 255, 0, 0, 0, 0, 0, 0);
    // byte-enable write with same-cycle read-first, then read back
    step(1, 4'b0101, 3, 32'hAABBCCDD, 0, 0, 0, 0, 0);
    step(1, 0, 3, 0, 0, 0, 0, 0, 0);
    // both ports write addr 7: A's bytes win, B fills the rest
    step(1, 4'b0011, 7, 32'h11111111, 1, 4'b1111, 7, 32'h22222222, 0);
    step(1, 0, 7, 0, 1, 0, 7, 0, 0);
    // cross-port read of an address being written returns the old word
    step(1, 4'b1111, 10, 32'hDEADBEEF, 1, 0, 10, 0, 0);
    step(0, 0, 0, 0, 1, 0, 10, 0, 0);
    // out-of-range access (with write enables) must not alias into the array
    step(0, 0, 0, 0, 1, 4'b1111, 300, 32'hCAFEF00D, 0);
    step(0, 0, 0, 0, 1, 0, 44, 0, 0);
    step(1, 0, 255, 0, 1, 0, 256, 0, 0);
    idle(4);
    chk("a_hold", bram_dout_a, last_a);
    chk("b_hold", bram_dout_b, last_b);

    // random traffic including collisions and out-of-range addresses
    for (int i = 0; i < 60; i++) begin
      aa = $urandom_range(0, DEPTH + 7);
      ab = ($urandom_range(0, 3) == 0) ? aa : $urandom_range(0, DEPTH + 7);
      step($urandom_range(0, 1), 4'($urandom), aa, $urandom,
           $urandom_range(0, 1), 4'($urandom), ab, $urandom, 0);
    end
    idle(4);

    // re-init after a write, accesses during INIT ignored, reset mid-sweep restarts it
    step(1, 4'b1111, 9, 32'h99999999, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 9, 0, 0);
    idle(3);
    bram_init = 1'b1;
    @(posedge bram_clk); #1;
    bram_init = 1'b0;
    step(1, 4'b1111, 9, 32'h12345678, 1, 4'b1111, 20, 32'h87654321, 1);
    step(1, 0, 9, 0, 1, 0, 300, 0, 1);
    idle(97);
    chk("init_hold_a", bram_dout_a, last_a);
    chk("init_busy_mid", init_busy, 1);
    bram_rst_n = 1'b0;
    #1;
    chk_reset_vals();
    last_a = '0; last_b = '0;
    repeat (2) @(posedge bram_clk);
    #1;
    bram_rst_n = 1'b1;
    wait_init(-1, n);
    chk("reinit_len", n, DEPTH);
    model_init();
    step(1, 0, 9, 0, 1, 0, 20, 0, 0);
    step(1, 0, 0, 0, 1, 0, 255, 0, 0);
    idle(4);

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
